divider_variable_mc: RTL and testbench
======================================

// Module: divider_variable_mc
// PURPOSE
//  NCH independent variable clock dividers in one block, for the synthesizer tone/LFO generators.
//  Each channel makes a near-50% square wave with a period of div_num system clocks, plus a
//  one-cycle rising-edge tick.
//  A new div_num takes effect only at a period boundary, so the output never has a runt or glitch.
//  Per-channel enable with graceful stop, and per-channel sync for phase reset (hard sync).
// PARAMETERS
//  N    16  width of each div_num field (period in clk cycles, 2..2^N-1)
//  NCH  4   number of channels
// PORTS
//  clk      in   1      system clock, all logic on posedge
//  rst      in   1      asynchronous active-high reset
//  en       in   NCH    per-channel enable, level
//  sync     in   NCH    per-channel phase-reset strobe, 1 cycle
//  div_num  in   NCH*N  per-channel period; channel i uses div_num[i*N +: N]
//  out      out  NCH    divided clock per channel, registered
//  rise     out  NCH    1-cycle pulse, high in the first cycle out[i] is high, registered
// BEHAVIOUR
//  - Reset (async, any time): every channel goes to IDLE, with cnt=0, P=0, out=0, rise=0.
//    No partial period is kept.
//  - Per-channel state: IDLE / LOW / HIGH.
//    - Phase counter cnt is N-1 bits.
//    - Shadow period P is N bits.
//  - out[i] = (state==HIGH), registered. rise[i] is 1 only in the first HIGH cycle.
//  - Phase lengths: LOW lasts floor(P/2) cycles and HIGH lasts ceil(P/2) cycles. The period is
//    exactly P; for odd P the HIGH phase is the longer one.
//  - "Valid load" means en[i]=1 and div_num field >= 2. On a valid load the field is copied
//    into P and the channel enters LOW with cnt=0.
//  - IDLE: out=0. When a valid load is sampled at edge k, the channel enters LOW at edge k.
//    The first rising edge of out then comes at edge k+floor(P/2).
//  - LOW: cnt increments each cycle. When cnt == floor(P/2)-1, the channel goes to HIGH
//    and cnt returns to 0.
//  - HIGH: cnt increments each cycle. At cnt == ceil(P/2)-1 (the period boundary):
//    - if a valid load is present: recapture P and go to LOW;
//    - otherwise go to IDLE.
//  - Because of this, a div_num change mid-period is ignored until the boundary.
//    Dropping en mid-period lets the current period finish, then the channel idles low.
//  - sync[i]=1 in any state overrides the boundary logic:
//    - if a valid load is present: recapture P, go to LOW with cnt=0. This may cut the current
//      phase short (intended hard sync).
//    - otherwise go to IDLE immediately.
//  - div_num of 0 or 1 is never loaded; the channel stays in, or falls to, IDLE.
//  - Channels are fully independent. There is no cross-channel interaction or shared counter.
//  - Width rule: ceil(P/2)-1 <= 2^(N-1)-1, so cnt never wraps.
//    The compares use the stored P, never the live div_num.
//  - Latency: changes to en, sync or div_num act on the next clock edge. There is no
//    extra pipeline delay.
// TESTING
//  1. ch0 div_num=4, en=1 -> out0 repeats 2 low, 2 high. rise0 pulses every 4 cycles,
//     aligned with the first high cycle.
//  2. ch1 div_num=5 -> 2 low, 3 high, period 5.
//     ch2 div_num=65535 (N=16) -> 32767 low, 32768 high, with no counter wrap.
//  3. ch0 running at 4; change div_num to 10 in the middle of a HIGH phase -> that period
//     still ends at 4 cycles, and the next period is 5 low, 5 high.
//  4. Deassert en0 in the 1st HIGH cycle of P=6 -> out0 stays high for 2 more cycles, then
//     stays 0 (IDLE). Re-assert en0 -> the first rise comes 3 cycles after the enabling edge.
//  5. sync1 during the HIGH phase of P=8 -> out1 drops the next cycle, then 4 low, 4 high.
//     sync1 with en1=0 -> out1 goes low and stays low.
//  6. Assert rst asynchronously mid-HIGH on all channels -> all out/rise are 0 immediately.
//     After release, each channel with en=1 restarts with a full LOW phase.
//     Also: div_num=1 with en=1 -> out stays 0.

Source files
------------

// File: rtl/divider_variable_mc.sv
// Multi-channel variable clock divider: per-channel square wave of period div_num with a
// rising-edge tick, glitch-free period updates, graceful stop and hard sync.
module divider_variable_mc #(
    parameter int unsigned N   = 16,
    parameter int unsigned NCH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic [NCH-1:0]   sync,
    input  logic [NCH*N-1:0] div_num,
    output logic [NCH-1:0]   out,
    output logic [NCH-1:0]   rise
);

    localparam int unsigned CW = N - 1;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } state_t;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t          state;
        logic [CW-1:0]   cnt;
        logic [N-1:0]    per;
        logic            out_q;
        logic            rise_q;
        logic [N-1:0]    fld;
        logic            load_ok;
        logic [CW-1:0]   half_lo;
        logic [CW-1:0]   lo_last;
        logic [CW-1:0]   hi_last;

        assign fld     = div_num[i*N +: N];
        assign load_ok = en[i] && (fld >= N'(2));

        // Phase end points derive from the stored period only; odd periods lengthen HIGH.
        assign half_lo = per[N-1:1];
        assign lo_last = half_lo - CW'(1);
        assign hi_last = per[0] ? half_lo : lo_last;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= IDLE;
                cnt    <= '0;
                per    <= '0;
                out_q  <= 1'b0;
                rise_q <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                if (sync[i]) begin
                    // Hard sync: restart the period now, or stop if no valid load.
                    cnt   <= '0;
                    out_q <= 1'b0;
                    if (load_ok) begin
                        per   <= fld;
                        state <= LOW;
                    end else begin
                        state <= IDLE;
                    end
                end else begin
                    case (state)
                        IDLE: begin
                            out_q <= 1'b0;
                            if (load_ok) begin
                                per   <= fld;
                                cnt   <= '0;
                                state <= LOW;
                            end
                        end
                        LOW: begin
                            if (cnt == lo_last) begin
                                cnt    <= '0;
                                state  <= HIGH;
                                out_q  <= 1'b1;
                                rise_q <= 1'b1;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        HIGH: begin
                            if (cnt == hi_last) begin
                                // Period boundary: the only point where a new period is taken.
                                cnt   <= '0;
                                out_q <= 1'b0;
                                if (load_ok) begin
                                    per   <= fld;
                                    state <= LOW;
                                end else begin
                                    state <= IDLE;
                                end
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        default: begin
                            cnt   <= '0;
                            out_q <= 1'b0;
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end

        assign out[i]  = out_q;
        assign rise[i] = rise_q;
    end

endmodule

// File: tb/tb_divider_variable_mc.sv
// Directed self-checking bench for divider_variable_mc: waveform windows per channel are
// compared against hand-derived bit patterns (first sample is the leftmost bit).
module tb_divider_variable_mc;

    localparam int unsigned N   = 16;
    localparam int unsigned NCH = 4;

    logic             clk;
    logic             rst;
    logic [NCH-1:0]   en;
    logic [NCH-1:0]   sync;
    logic [NCH*N-1:0] div_num;
    logic [NCH-1:0]   out;
    logic [NCH-1:0]   rise;

    int n_total = 0;
    int n_pass  = 0;

    logic [63:0] ob [NCH];
    logic [63:0] rb [NCH];

    divider_variable_mc #(.N(N), .NCH(NCH)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .div_num (div_num),
        .out     (out),
        .rise    (rise)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_div(input int ch, input int val);
        div_num[ch*N +: N] = N'(val);
    endtask

    // Capture n cycles of every channel, sampled 1 time unit after each rising edge.
    task automatic cap(input int n);
        for (int c = 0; c < NCH; c++) begin
            ob[c] = '0;
            rb[c] = '0;
        end
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
            for (int c = 0; c < NCH; c++) begin
                ob[c] = {ob[c][62:0], out[c]};
                rb[c] = {rb[c][62:0], rise[c]};
            end
        end
    endtask

    task automatic wait_rise(input int ch, input int limit);
        bit seen;
        seen = 1'b0;
        for (int j = 0; j < limit && !seen; j++) begin
            @(posedge clk);
            #1;
            seen = rise[ch];
        end
        check($sformatf("wait_rise%0d", ch), 64'(seen), 64'(1));
    endtask

    initial begin
        int lo;
        int hi;
        rst     = 1'b1;
        en      = '0;
        sync    = '0;
        div_num = '0;

        // Reset state, then ch0 P=4, ch1 P=5, ch2 P=65535
        set_div(0, 4);
        set_div(1, 5);
        set_div(2, 65535);
        en = 4'b0111;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", 64'(out), 64'(0));
        check("reset_rise", 64'(rise), 64'(0));
        rst = 1'b0;

        cap(10);
        check("p4_out", ob[0], 64'(10'b0011001100));
        check("p4_rise", rb[0], 64'(10'b0010001000));
        check("p5_out", ob[1], 64'(10'b0011100111));
        check("p5_rise", rb[1], 64'(10'b0010000100));
        check("p65535_early", ob[2], 64'(0));

        // Long channel: 32767 low then 32768 high, no wrap
        lo = 10;
        for (int j = 0; j < 40000 && !out[2]; j++) begin
            @(posedge clk);
            #1;
            if (!out[2]) lo++;
        end
        check("p65535_low", 64'(lo), 64'(32767));
        check("p65535_rise", 64'(rise[2]), 64'(1));
        hi = 1;
        for (int j = 0; j < 40000 && out[2]; j++) begin
            @(posedge clk);
            #1;
            if (out[2]) hi++;
        end
        check("p65535_high", 64'(hi), 64'(32768));
        en[2] = 1'b0;

        // div_num change mid-HIGH only takes effect at the boundary
        wait_rise(0, 20);
        set_div(0, 10);
        cap(12);
        check("chg_out", ob[0], 64'(12'b100000111110));
        check("chg_rise", rb[0], 64'(12'b000000100000));

        // Graceful stop at P=6, then restart
        set_div(0, 6);
        wait_rise(0, 30);
        wait_rise(0, 30);
        en[0] = 1'b0;
        cap(6);
        check("stop_out", ob[0], 64'(6'b110000));
        check("stop_rise", rb[0], 64'(6'b000000));
        en[0] = 1'b1;
        cap(6);
        check("restart_out", ob[0], 64'(6'b000111));
        check("restart_rise", rb[0], 64'(6'b000100));

        // Hard sync during HIGH of P=8
        set_div(1, 8);
        wait_rise(1, 30);
        wait_rise(1, 30);
        sync[1] = 1'b1;
        cap(1);
        sync[1] = 1'b0;
        check("sync_drop", ob[1], 64'(0));
        cap(8);
        check("sync_out", ob[1], 64'(8'b00011110));
        check("sync_rise", rb[1], 64'(8'b00010000));
        wait_rise(1, 30);
        en[1]   = 1'b0;
        sync[1] = 1'b1;
        cap(1);
        sync[1] = 1'b0;
        check("sync_off_drop", ob[1], 64'(0));
        cap(10);
        check("sync_off_stay", ob[1], 64'(0));

        // Async reset mid-HIGH; restart with full LOW; div_num=1 never loads
        set_div(1, 4);
        set_div(3, 1);
        en = 4'b1011;
        wait_rise(0, 30);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out", 64'(out), 64'(0));
        check("async_rst_rise", 64'(rise), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        cap(4);
        check("post_rst_ch0", ob[0], 64'(4'b0001));
        check("post_rst_ch1", ob[1], 64'(4'b0011));
        check("post_rst_ch2", ob[2], 64'(0));
        cap(10);
        check("div1_out", ob[3], 64'(0));
        check("div1_rise", rb[3], 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
